// File: rtl/matrix_mul_pkg.sv
// Shared definitions for the matrix_mul MAC: FSM encodings, step count and the
// mapping from the 3-bit step counter onto the (i, j, k) element indices.
package matrix_mul_pkg;

    localparam int MAC_STEPS  = 8;
    localparam int STEP_W     = 3;
    localparam int STEP_I_BIT = 2;
    localparam int STEP_J_BIT = 1;
    localparam int STEP_K_BIT = 0;

    typedef enum logic [1:0] {
        MAC_IDLE  = 2'd0,
        MAC_MUL   = 2'd1,
        MAC_DRAIN = 2'd2,
        MAC_DONE  = 2'd3
    } mac_state_e;

    typedef logic [STEP_W-1:0] mac_step_t;

    // Element indices are row-major: x_11=0, x_12=1, x_21=2, x_22=3.
    function automatic logic [1:0] a_index(input mac_step_t s);
        return {s[STEP_I_BIT], s[STEP_K_BIT]};
    endfunction

    function automatic logic [1:0] b_index(input mac_step_t s);
        return {s[STEP_K_BIT], s[STEP_J_BIT]};
    endfunction

    function automatic logic [1:0] c_index(input mac_step_t s);
        return {s[STEP_I_BIT], s[STEP_J_BIT]};
    endfunction

endpackage

// File: rtl/matrix_mac_2x2_if.sv
// Handshake, operand and result bundle between the matrix_mul control unit
// (master) and the 2x2 multiply-accumulate responder (slave).
interface matrix_mac_2x2_if #(
    parameter int data_w = 32
);
    logic                     start_mac;
    logic                     clear_acc;
    logic signed [data_w-1:0] a_11, a_12, a_21, a_22;
    logic signed [data_w-1:0] b_11, b_12, b_21, b_22;
    logic signed [data_w-1:0] c_11, c_12, c_21, c_22;
    logic                     done_mac;
    logic                     busy;
    logic                     ovf;

    modport master (
        output start_mac, clear_acc,
        output a_11, a_12, a_21, a_22,
        output b_11, b_12, b_21, b_22,
        input  c_11, c_12, c_21, c_22,
        input  done_mac, busy, ovf
    );

    modport slave (
        input  start_mac, clear_acc,
        input  a_11, a_12, a_21, a_22,
        input  b_11, b_12, b_21, b_22,
        output c_11, c_12, c_21, c_22,
        output done_mac, busy, ovf
    );

endinterface

// File: rtl/mac_acc_add.sv
// Signed accumulator adder with overflow detect. Define MATRIX_MAC_SAT_EN to
// clamp the sum to the signed range instead of wrapping.
module mac_acc_add #(
    parameter int data_w = 32
) (
    input  logic signed [data_w-1:0] a,
    input  logic signed [data_w-1:0] b,
    output logic signed [data_w-1:0] sum,
    output logic                     ovf
);

    logic signed [data_w-1:0] raw;

    // Overflow only when both operands share a sign and the result flips it.
    always_comb begin
        raw = a + b;
        ovf = (a[data_w-1] == b[data_w-1]) && (raw[data_w-1] != a[data_w-1]);
`ifdef MATRIX_MAC_SAT_EN
        if (ovf)
            sum = a[data_w-1] ? {1'b1, {(data_w-1){1'b0}}} : {1'b0, {(data_w-1){1'b1}}};
        else
            sum = raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/matrix_mac_2x2.sv
// 2x2 block multiply-accumulate responder using one shared multiplier over 8 steps.
// Define MATRIX_MAC_SAT_EN to saturate products and sums instead of wrapping.
module matrix_mac_2x2 #(
    parameter int data_w = 32
) (
    input  logic            clk,
    input  logic            rst,
    matrix_mac_2x2_if.slave bus
);
    import matrix_mul_pkg::*;

    localparam mac_step_t LAST_STEP = mac_step_t'(MAC_STEPS - 1);

    mac_state_e state, state_nxt;
    mac_step_t  step, step_prev;

    logic signed [data_w-1:0]   a_q [4];
    logic signed [data_w-1:0]   b_q [4];
    logic signed [data_w-1:0]   c_q [4];
    logic signed [data_w-1:0]   prod_q;
    logic                       prod_ovf_q;
    logic                       ovf_q;

    logic                       latch_en, mul_en, acc_en;
    logic                       busy, done;
    logic [1:0]                 acc_idx;

    logic signed [2*data_w-1:0] a_ext, b_ext, prod_full;
    logic signed [data_w-1:0]   prod_val;
    logic                       prod_trunc_ovf;
    logic signed [data_w-1:0]   acc_cur, sum;
    logic                       sum_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= MAC_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MAC_IDLE:  if (bus.start_mac)   state_nxt = MAC_MUL;
            MAC_MUL:   if (step == LAST_STEP) state_nxt = MAC_DRAIN;
            MAC_DRAIN: state_nxt = MAC_DONE;
            MAC_DONE:  if (!bus.start_mac)  state_nxt = MAC_IDLE;
            default:   state_nxt = MAC_IDLE;
        endcase
    end

    // The step counter has wrapped to 0 by DRAIN, so step-1 still names step 7.
    always_comb begin
        latch_en = (state == MAC_IDLE) && bus.start_mac;
        mul_en   = (state == MAC_MUL);
        acc_en   = ((state == MAC_MUL) && (step != '0)) || (state == MAC_DRAIN);
        busy     = (state == MAC_MUL) || (state == MAC_DRAIN);
        done     = (state == MAC_DONE);
    end

    assign step_prev = step - mac_step_t'(1);
    assign acc_idx   = c_index(step_prev);
    assign acc_cur   = c_q[acc_idx];

    assign a_ext     = {{data_w{a_q[a_index(step)][data_w-1]}}, a_q[a_index(step)]};
    assign b_ext     = {{data_w{b_q[b_index(step)][data_w-1]}}, b_q[b_index(step)]};
    assign prod_full = a_ext * b_ext;

    // Truncation is lossless only if the upper data_w+1 bits are all sign copies.
    always_comb begin
        prod_trunc_ovf = (prod_full[2*data_w-1:data_w-1] != {(data_w+1){prod_full[2*data_w-1]}});
`ifdef MATRIX_MAC_SAT_EN
        if (prod_trunc_ovf)
            prod_val = prod_full[2*data_w-1] ? {1'b1, {(data_w-1){1'b0}}}
                                             : {1'b0, {(data_w-1){1'b1}}};
        else
            prod_val = prod_full[data_w-1:0];
`else
        prod_val = prod_full[data_w-1:0];
`endif
    end

    mac_acc_add #(
        .data_w (data_w)
    ) u_acc_add (
        .a   (acc_cur),
        .b   (prod_q),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
            prod_q     <= '0;
            prod_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
            step       <= '0;
        end else begin
            if (latch_en) begin
                a_q[0] <= bus.a_11;
                a_q[1] <= bus.a_12;
                a_q[2] <= bus.a_21;
                a_q[3] <= bus.a_22;
                b_q[0] <= bus.b_11;
                b_q[1] <= bus.b_12;
                b_q[2] <= bus.b_21;
                b_q[3] <= bus.b_22;
                if (bus.clear_acc) begin
                    for (int n = 0; n < 4; n++)
                        c_q[n] <= '0;
                    ovf_q <= 1'b0;
                end
                step <= '0;
            end
            if (mul_en) begin
                prod_q     <= prod_val;
                prod_ovf_q <= prod_trunc_ovf;
                step       <= step + mac_step_t'(1);
            end
            if (acc_en) begin
                c_q[acc_idx] <= sum;
                ovf_q        <= ovf_q | prod_ovf_q | sum_ovf;
            end
        end
    end

    assign bus.c_11     = c_q[0];
    assign bus.c_12     = c_q[1];
    assign bus.c_21     = c_q[2];
    assign bus.c_22     = c_q[3];
    assign bus.done_mac = done;
    assign bus.busy     = busy;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_matrix_mac_2x2.sv
// Directed bench for matrix_mac_2x2: a 32-bit instance for the main function and
// an 8-bit instance for overflow; honours MATRIX_MAC_SAT_EN for expected values.
module tb_matrix_mac_2x2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    matrix_mac_2x2_if #(.data_w(32)) bus32 ();
    matrix_mac_2x2_if #(.data_w(8))  bus8 ();

    matrix_mac_2x2 #(.data_w(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    matrix_mac_2x2 #(.data_w(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] c32(input int n);
        case (n)
            0:       return bus32.c_11;
            1:       return bus32.c_12;
            2:       return bus32.c_21;
            default: return bus32.c_22;
        endcase
    endfunction

    function automatic logic [7:0] c8(input int n);
        case (n)
            0:       return bus8.c_11;
            1:       return bus8.c_12;
            2:       return bus8.c_21;
            default: return bus8.c_22;
        endcase
    endfunction

    task automatic applyStimulus(input bit use8, input bit start, input bit clear,
                                 input int a11, input int a12, input int a21, input int a22,
                                 input int b11, input int b12, input int b21, input int b22);
        if (use8) begin
            bus8.start_mac = start;   bus8.clear_acc = clear;
            bus8.a_11 = 8'(a11);      bus8.a_12 = 8'(a12);
            bus8.a_21 = 8'(a21);      bus8.a_22 = 8'(a22);
            bus8.b_11 = 8'(b11);      bus8.b_12 = 8'(b12);
            bus8.b_21 = 8'(b21);      bus8.b_22 = 8'(b22);
        end else begin
            bus32.start_mac = start;  bus32.clear_acc = clear;
            bus32.a_11 = a11;         bus32.a_12 = a12;
            bus32.a_21 = a21;         bus32.a_22 = a22;
            bus32.b_11 = b11;         bus32.b_12 = b12;
            bus32.b_21 = b21;         bus32.b_22 = b22;
        end
    endtask

    // Called right after a negedge with start_mac raised; returns edges from accept to done.
    task automatic wait_done(input bit use8, output int lat);
        lat = -1;
        @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((use8 ? bus8.done_mac : bus32.done_mac) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_op(input bit use8);
        if (use8) bus8.start_mac = 1'b0;
        else      bus32.start_mac = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_c%0d got %0d want 0", n, c32(n));
            end
        end
        checks++;
        if ({bus32.done_mac, bus32.busy, bus32.ovf} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 000", {bus32.done_mac, bus32.busy, bus32.ovf});
        end
        checks++;
        if ({bus8.done_mac, bus8.busy, bus8.ovf} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags8 got %b want 000", {bus8.done_mac, bus8.busy, bus8.ovf});
        end
    endtask

    task automatic test_identity();
        int lat;
        int exp [4] = '{1, 2, 3, 4};
        applyStimulus(0, 1, 1, 1, 0, 0, 1, 1, 2, 3, 4);
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ident_busy got %b want 1", bus32.busy);
        end
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (bus32.done_mac === 1'b1) begin
                lat = n - 1;
                break;
            end
            lat = -1;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL ident_latency got %0d want 9", lat);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'(exp[n])) begin
                errors++;
                $display("[TB] FAIL ident_c%0d got %0d want %0d", n, c32(n), exp[n]);
            end
        end
        checks++;
        if ({bus32.ovf, bus32.busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ident_ovf_busy got %b want 00", {bus32.ovf, bus32.busy});
        end
        finish_op(0);
    endtask

    task automatic test_accumulate();
        int lat;
        int exp1 [4] = '{19, 22, 43, 50};
        int exp2 [4] = '{38, 44, 86, 100};
        applyStimulus(0, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8);
        wait_done(0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL acc1_latency got %0d want 9", lat);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'(exp1[n])) begin
                errors++;
                $display("[TB] FAIL acc1_c%0d got %0d want %0d", n, c32(n), exp1[n]);
            end
        end
        finish_op(0);
        applyStimulus(0, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8);
        wait_done(0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL acc2_latency got %0d want 9", lat);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'(exp2[n])) begin
                errors++;
                $display("[TB] FAIL acc2_c%0d got %0d want %0d", n, c32(n), exp2[n]);
            end
        end
        checks++;
        if (bus32.ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL acc2_ovf got %b want 0", bus32.ovf);
        end
        finish_op(0);
    endtask

    task automatic test_hold_done();
        int lat;
        applyStimulus(0, 1, 1, 2, 0, 0, 2, 1, 1, 1, 1);
        wait_done(0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL hold_latency got %0d want 9", lat);
        end
        // Keep start high and disturb operands/clear: result must stay frozen.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(0, 1, n[0], 9, 9, 9, 9, 9, 9, 9, 9);
            @(negedge clk);
            checks++;
            if ({bus32.done_mac, bus32.c_11, bus32.c_22} !== {1'b1, 32'd2, 32'd2}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d got done=%b c11=%0d c22=%0d want done=1 c11=2 c22=2",
                         n, bus32.done_mac, bus32.c_11, bus32.c_22);
            end
        end
        finish_op(0);
        checks++;
        if ({bus32.done_mac, bus32.busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL hold_release got done/busy=%b want 00", {bus32.done_mac, bus32.busy});
        end
        checks++;
        if (bus32.c_12 !== 32'd2) begin
            errors++;
            $display("[TB] FAIL hold_idle_c12 got %0d want 2", bus32.c_12);
        end
    endtask

    task automatic test_overflow8();
        int lat;
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        logic [7:0] exp3 [4];
`ifdef MATRIX_MAC_SAT_EN
        exp1 = '{8'h7F, 8'h00, 8'h00, 8'h00};
        exp2 = '{8'h7F, 8'h00, 8'h00, 8'h00};
`else
        exp1 = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp2 = '{8'hC8, 8'h00, 8'h00, 8'h00};
`endif
        exp3 = '{8'h01, 8'h00, 8'h00, 8'h01};
        // 127*127 loses significance when truncated to 8 bits.
        applyStimulus(1, 1, 1, 127, 0, 0, 0, 127, 0, 0, 0);
        wait_done(1, lat);
        checks++;
        if ({bus8.done_mac, bus8.ovf} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ovf8_prod_flags got done/ovf=%b want 11", {bus8.done_mac, bus8.ovf});
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c8(n) !== exp1[n]) begin
                errors++;
                $display("[TB] FAIL ovf8_prod_c%0d got %h want %h", n, c8(n), exp1[n]);
            end
        end
        finish_op(1);
        // 100 + 100 overflows the adder with no product overflow.
        applyStimulus(1, 1, 1, 100, 100, 0, 0, 1, 0, 1, 0);
        wait_done(1, lat);
        checks++;
        if ({bus8.done_mac, bus8.ovf} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL ovf8_sum_flags got done/ovf=%b want 11", {bus8.done_mac, bus8.ovf});
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c8(n) !== exp2[n]) begin
                errors++;
                $display("[TB] FAIL ovf8_sum_c%0d got %h want %h", n, c8(n), exp2[n]);
            end
        end
        finish_op(1);
        applyStimulus(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1);
        wait_done(1, lat);
        checks++;
        if ({bus8.done_mac, bus8.ovf} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ovf8_clear_flags got done/ovf=%b want 10", {bus8.done_mac, bus8.ovf});
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c8(n) !== exp3[n]) begin
                errors++;
                $display("[TB] FAIL ovf8_clear_c%0d got %h want %h", n, c8(n), exp3[n]);
            end
        end
        finish_op(1);
    endtask

    task automatic test_operand_change();
        int exp [4] = '{19, 22, 43, 50};
        bit seen = 0;
        applyStimulus(0, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus32.done_mac === 1'b1) begin
                seen = 1;
                break;
            end
            applyStimulus(0, 1, n[0], 50 + n, -3, 7 * n, 11, -9, n, 13, 100);
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chg_done got timeout want done_mac=1");
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'(exp[n])) begin
                errors++;
                $display("[TB] FAIL chg_c%0d got %0d want %0d", n, c32(n), exp[n]);
            end
        end
        finish_op(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        int exp [4] = '{1, 2, 3, 4};
        applyStimulus(0, 1, 0, 1, 2, 3, 4, 5, 6, 7, 8);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'd0) begin
                errors++;
                $display("[TB] FAIL rstmid_c%0d got %0d want 0", n, c32(n));
            end
        end
        checks++;
        if ({bus32.done_mac, bus32.busy, bus32.ovf} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rstmid_flags got %b want 000", {bus32.done_mac, bus32.busy, bus32.ovf});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 1, 2, 3, 4);
        wait_done(0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL rstmid_latency got %0d want 9", lat);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c32(n) !== 32'(exp[n])) begin
                errors++;
                $display("[TB] FAIL rstmid_c%0d_after got %0d want %0d", n, c32(n), exp[n]);
            end
        end
        finish_op(0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_identity();
        test_accumulate();
        test_hold_done();
        test_overflow8();
        test_operand_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
